// File: rtl/ecc_decoder_if.sv
// Read-return bus for ecc_decoder: codeword ready/valid in, decoded word ready/valid out.
// The master side is the codeword source and the downstream sink.
interface ecc_decoder_if #(
    parameter int unsigned DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W+7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par_err;
    logic              out_fmt_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_par_err, out_fmt_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_par_err, out_fmt_err
    );
endinterface

// File: rtl/ecc_decoder.sv
// ECC receive checker: two-stage ready/valid pipeline flagging parity and reserved-bit errors.
// Define ECC_ERR_COUNT_EN to add the saturating error-word counter on err_count.
module ecc_decoder #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    ecc_decoder_if.slave     bus,
    input  logic             err_clear,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);
    localparam int unsigned CW_W = DATA_W + 8;

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_word_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_par_q;
    logic              s2_fmt_q;
    logic              err_sticky_q;
    logic              s1_adv;
    logic              s2_adv;
    logic              s1_par;
    logic              s1_fmt;
    logic              err_event;

    // Ready ripples combinationally from out_ready so a streaming pipe never bubbles.
    always_comb begin
        s2_adv    = !s2_valid_q || bus.out_ready;
        s1_adv    = !s1_valid_q || s2_adv;
        s1_par    = (^s1_word_q[DATA_W-1:0]) ^ s1_word_q[DATA_W];
        s1_fmt    = |s1_word_q[CW_W-1:DATA_W+1];
        err_event = s2_valid_q && bus.out_ready && (s2_par_q || s2_fmt_q);
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_data    = s2_data_q;
    assign bus.out_par_err = s2_par_q;
    assign bus.out_fmt_err = s2_fmt_q;
    assign err_sticky      = err_sticky_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_word_q <= bus.in_data;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_par_q   <= 1'b0;
            s2_fmt_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_word_q[DATA_W-1:0];
                s2_par_q  <= s1_par;
                s2_fmt_q  <= s1_fmt;
            end
        end
    end

    // Clear beats a coincident error event; that event is simply not recorded.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_sticky_q <= 1'b0;
        end else if (err_clear) begin
            err_sticky_q <= 1'b0;
        end else if (err_event) begin
            err_sticky_q <= 1'b1;
        end
    end

`ifdef ECC_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_count_q <= '0;
        end else if (err_clear) begin
            err_count_q <= '0;
        end else if (err_event && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_ecc_decoder.sv
// Self-checking bench for ecc_decoder: scoreboard queue of expected words plus a small
// sticky/counter model; expected counts honour ECC_ERR_COUNT_EN.
module tb_ecc_decoder;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
`ifdef ECC_ERR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              fmt;
    } exp_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b0;
    logic             err_clear = 1'b0;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    ecc_decoder_if #(.DATA_W(DATA_W)) bus ();

    ecc_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bus       (bus),
        .err_clear (err_clear),
        .err_sticky(err_sticky),
        .err_count (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    bit   m_sticky;
    int   m_cnt;

    function automatic exp_t make_exp(input logic [DATA_W+7:0] cw);
        exp_t e;
        e.data = cw[DATA_W-1:0];
        e.par  = (^cw[DATA_W-1:0]) ^ cw[DATA_W];
        e.fmt  = |cw[DATA_W+7:DATA_W+1];
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] want_count();
        return CNT_ON ? CNT_W'(m_cnt) : '0;
    endfunction

    function automatic void model_xfer(input logic err, input logic clr);
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else if (err) begin
            m_sticky = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        err_clear     = 1'b0;
        #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        sb.delete();
        m_sticky = 1'b0;
        m_cnt    = 0;
        @(negedge sys_clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 64'h0) begin
            failures++; $display("FAIL reset_out_data got=%h want=0", bus.out_data);
        end
        checks++;
        if ({bus.out_par_err, bus.out_fmt_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00", {bus.out_par_err, bus.out_fmt_err});
        end
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++; $display("FAIL reset_sticky got=%0b want=0", err_sticky);
        end
        checks++;
        if (err_count !== 4'd0) begin
            failures++; $display("FAIL reset_count got=%0d want=0", err_count);
        end
    endtask

    task automatic test_directed();
        logic [DATA_W+7:0] cw [3];
        bit               want_par [3];
        bit               want_fmt [3];
        bit               want_stk [3];
        int               want_cnt [3];
        logic [CNT_W-1:0] wc;
        exp_t             e;
        cw[0] = {8'h00, 64'h0123_4567_89AB_CDEF};
        cw[1] = {8'h00, 64'h0123_4567_89AB_CDEF ^ (64'd1 << 17)};
        cw[2] = {8'h81, 64'h0123_4567_89AB_CDEF};
        want_par = '{1'b0, 1'b1, 1'b1};
        want_fmt = '{1'b0, 1'b0, 1'b1};
        want_stk = '{1'b0, 1'b1, 1'b1};
        want_cnt = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            bus.in_valid  = 1'b1;
            bus.in_data   = cw[i];
            bus.out_ready = 1'b1;
            @(negedge sys_clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++; $display("FAIL dir%0d_in_ready got=%0b want=1", i, bus.in_ready);
            end
            if (bus.in_ready) sb.push_back(make_exp(cw[i]));
            @(posedge sys_clk); #1 bus.in_valid = 1'b0;
            @(negedge sys_clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL dir%0d_early_valid got=%0b want=0", i, bus.out_valid);
            end
            @(posedge sys_clk);
            @(negedge sys_clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL dir%0d_latency got=%0b want=1", i, bus.out_valid);
            end
            if (bus.out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.out_data !== e.data) begin
                    failures++;
                    $display("FAIL dir%0d_data got=%h want=%h", i, bus.out_data, e.data);
                end
                checks++;
                if (bus.out_par_err !== want_par[i]) begin
                    failures++;
                    $display("FAIL dir%0d_par got=%0b want=%0b", i, bus.out_par_err, want_par[i]);
                end
                checks++;
                if (bus.out_fmt_err !== want_fmt[i]) begin
                    failures++;
                    $display("FAIL dir%0d_fmt got=%0b want=%0b", i, bus.out_fmt_err, want_fmt[i]);
                end
                model_xfer(e.par | e.fmt, 1'b0);
            end
            @(posedge sys_clk);
            @(negedge sys_clk);
            checks++;
            if (err_sticky !== want_stk[i]) begin
                failures++;
                $display("FAIL dir%0d_sticky got=%0b want=%0b", i, err_sticky, want_stk[i]);
            end
            wc = CNT_ON ? CNT_W'(want_cnt[i]) : '0;
            checks++;
            if (err_count !== wc) begin
                failures++; $display("FAIL dir%0d_count got=%0d want=%0d", i, err_count, wc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W+7:0] words [8];
        logic [7:0]        chk;
        int                sent = 0;
        int                got = 0;
        bit                saw_stall = 1'b0;
        bit                want_rdy;
        exp_t              e;
        for (int i = 0; i < 8; i++) begin
            chk = (i % 4 == 1) ? 8'h01 : ((i % 4 == 3) ? 8'h10 : 8'h00);
            words[i] = {chk, $urandom(), $urandom()};
        end
        @(posedge sys_clk); #1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = (sent < 8);
            bus.in_data   = words[sent % 8];
            @(negedge sys_clk);
            want_rdy = (sb.size() < 2) || bus.out_ready;
            checks++;
            if (bus.in_ready !== want_rdy) begin
                failures++;
                $display("FAIL b2b_in_ready c=%0d got=%0b want=%0b", c, bus.in_ready, want_rdy);
            end
            if (!bus.in_ready) saw_stall = 1'b1;
            checks++;
            if (err_sticky !== m_sticky || err_count !== want_count()) begin
                failures++;
                $display("FAIL b2b_err_state c=%0d got=%0b/%0d want=%0b/%0d", c, err_sticky,
                         err_count, m_sticky, want_count());
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b_extra_word got=%h want=none", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_data, bus.out_par_err, bus.out_fmt_err} !== e) begin
                        failures++;
                        $display("FAIL b2b_word%0d got=%h/%0b%0b want=%h/%0b%0b", got,
                                 bus.out_data, bus.out_par_err, bus.out_fmt_err,
                                 e.data, e.par, e.fmt);
                    end
                    model_xfer(e.par | e.fmt, err_clear);
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(make_exp(words[sent % 8]));
                sent++;
            end
            @(posedge sys_clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got !== 8 || sb.size() != 0) begin
            failures++; $display("FAIL b2b_count got=%0d left=%0d want=8/0", got, sb.size());
        end
        checks++;
        if (saw_stall !== 1'b1) begin
            failures++; $display("FAIL b2b_backpressure got=%0b want=1", saw_stall);
        end
    endtask

    task automatic test_counter();
        logic [DATA_W+7:0] cw;
        logic [CNT_W-1:0]  wc;
        int                sent = 0;
        int                got = 0;
        bit                found = 1'b0;
        exp_t              e;
        bus.out_ready = 1'b1;
        err_clear     = 1'b1;
        @(negedge sys_clk);
        model_xfer(1'b0, 1'b1);
        @(posedge sys_clk); #1 err_clear = 1'b0;
        for (int c = 0; c < 60 && got < 20; c++) begin
            cw = {8'h02, 32'h0, $urandom()};
            bus.in_valid = (sent < 20);
            bus.in_data  = cw;
            @(negedge sys_clk);
            checks++;
            if (err_count !== want_count()) begin
                failures++;
                $display("FAIL cnt_track c=%0d got=%0d want=%0d", c, err_count, want_count());
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                model_xfer(e.par | e.fmt, err_clear);
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(make_exp(cw));
                sent++;
            end
            @(posedge sys_clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        wc = CNT_ON ? 4'd15 : 4'd0;
        checks++;
        if (err_count !== wc) begin
            failures++; $display("FAIL cnt_saturate got=%0d want=%0d", err_count, wc);
        end
        @(posedge sys_clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = {8'h02, 64'h0};
        @(negedge sys_clk);
        if (bus.in_ready) sb.push_back(make_exp(bus.in_data));
        @(posedge sys_clk); #1 bus.in_valid = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge sys_clk);
            if (bus.out_valid) found = 1'b1;
            else @(posedge sys_clk);
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL cnt_clear_wait got=timeout want=out_valid");
        end else begin
            checks++;
            if (err_sticky !== 1'b1) begin
                failures++; $display("FAIL cnt_pre_clear_sticky got=%0b want=1", err_sticky);
            end
            err_clear = 1'b1;
            if (sb.size() > 0) void'(sb.pop_front());
            model_xfer(1'b1, 1'b1);
            @(posedge sys_clk); #1 err_clear = 1'b0;
            @(negedge sys_clk);
            checks++;
            if (err_count !== 4'd0 || err_sticky !== 1'b0) begin
                failures++;
                $display("FAIL cnt_clear_wins got=%0d/%0b want=0/0", err_count, err_sticky);
            end
        end
    endtask

    task automatic test_reset_inflight();
        bit seen = 1'b0;
        @(posedge sys_clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {8'h00, 64'hDEAD_BEEF_0000_0001};
        @(posedge sys_clk); #1;
        bus.in_data   = {8'h01, 64'hDEAD_BEEF_0000_0002};
        @(posedge sys_clk); #1;
        bus.in_valid  = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_prefill got=%0b/%0b want=1/0", bus.out_valid, bus.in_ready);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_async_valid got=%0b want=0", bus.out_valid);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        sb.delete();
        model_xfer(1'b0, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge sys_clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rst_lost_words got=%0b want=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_counter();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
